pipe_ctrl: RTL
==============

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have ports: rst  in  1  asynchronous, active-high reset.
REQ-003 SHALL have ports: id_rd_addr1/id_rd_addr2  in  REG_ADDR_WIDTH each  decode-stage source register addresses.
REQ-004 SHALL have ports: id_rd_en1/id_rd_en2  in  1 each  decode-stage source read enables.
REQ-005 SHALL have ports: ex_wr_addr  in  REG_ADDR_WIDTH  EX destination; ex_wr_en  in  1  EX write enable; ex_is_load  in  1  EX holds a load.
REQ-006 SHALL have ports: ex_mc_req  in  1  EX op is multi-cycle; ex_mc_cycles  in  4  total EX cycles for that op.
REQ-007 SHALL have ports: id_branch_taken  in  1  decode resolved a taken branch.
REQ-008 SHALL have ports: stall  out  6  hold vector, bit0 PC, bit1 IF/ID, bit2 ID/EX, bit3 EX/MEM, bit4 MEM/WB, bit5 reserved (always 0).
REQ-009 SHALL have ports: bubble_ex  out  1  ID/EX loads all-zero NOP; bubble_mem  out  1  EX/MEM loads NOP.
REQ-010 SHALL have ports: flush_if  out  1  IF/ID loads NOP; mc_busy  out  1  multi-cycle wait active; stall_cnt  out  16  stalled-cycle count.

Function
REQ-011 SHALL implement FSM states RUN and MC_WAIT, plus a 4-bit down-counter mc_cnt.
REQ-012 SHALL detect load-use, combinationally in the same cycle, as: state RUN, ex_is_load, ex_wr_en, ex_wr_addr != 0, and (id_rd_en1 with id_rd_addr1 == ex_wr_addr, or id_rd_en2 with id_rd_addr2 == ex_wr_addr).
REQ-013 SHALL drive stall = 6'b000111 and bubble_ex = 1 on load-use, for exactly one cycle per hazard instance.
REQ-014 SHALL treat ex_mc_req with ex_mc_cycles >= 2 in RUN as a multi-cycle start: drive stall = 6'b001111 and bubble_mem = 1 in that cycle, load mc_cnt = ex_mc_cycles - 2, and move to MC_WAIT.
REQ-015 SHALL hold stall = 6'b001111, bubble_mem = 1 and mc_busy = 1 in MC_WAIT; decrement mc_cnt each cycle; return to RUN on the cycle after mc_cnt == 0. Total stalled cycles = ex_mc_cycles - 1.
REQ-016 SHALL treat ex_mc_req with ex_mc_cycles of 0 or 1 as single-cycle: no stall, no state change.
REQ-017 SHALL give a multi-cycle start priority over load-use when both hold in the same cycle; load-use is then re-evaluated after return to RUN.
REQ-018 SHALL ignore ex_mc_req and load-use inputs while in MC_WAIT.
REQ-019 SHALL set flush_if = id_branch_taken & ~stall[2], so a taken branch is held until the stall clears.
REQ-020 SHALL drive stall, bubble_ex, bubble_mem and flush_if combinationally from state and inputs; mc_busy SHALL be decoded from state.
REQ-021 SHALL increment stall_cnt on every rising edge where stall[0] = 1, saturating at 16'hFFFF.

Reset
REQ-022 SHALL, on rst asserted at any time (including mid-MC_WAIT), immediately force state = RUN, mc_cnt = 0, stall_cnt = 0, mc_busy = 0.
REQ-023 SHALL keep all combinational outputs at 0 during reset regardless of inputs.

Configuration
REQ-024 SHALL, with PIPE_CTRL_MC_EN defined, implement REQ-014 to REQ-018.
REQ-025 SHALL, without PIPE_CTRL_MC_EN, keep the ex_mc_req/ex_mc_cycles ports but ignore them, omit MC_WAIT and mc_cnt, and tie bubble_mem = 0, mc_busy = 0 and stall[3] = 0.

Structure
REQ-026 SHALL place STALL_WIDTH (6), stall bit indices, the FSM state encoding and MC_CNT_WIDTH (4) in the shared package pipe_pkg; REG_ADDR_WIDTH comes from the existing shared defines.
REQ-027 SHALL implement stall_cnt in a sub-module sat_counter, parameterised by width, with inputs clk, rst, inc.

Verification
REQ-028 SHALL verify load-use: ex_is_load = 1, ex_wr_en = 1, ex_wr_addr = 5, id_rd_en2 = 1, id_rd_addr2 = 5 -> one cycle of stall = 000111, bubble_ex = 1, stall_cnt +1.
REQ-029 SHALL verify the $zero exception: same as REQ-028 but addresses = 0 -> stall = 0, bubble_ex = 0.
REQ-030 SHALL verify multi-cycle: ex_mc_req = 1, ex_mc_cycles = 5 -> stall = 001111 for 4 consecutive cycles, mc_busy high for cycles 2-4, RUN at cycle 5, stall_cnt = 4.
REQ-031 SHALL verify simultaneity: multi-cycle start (ex_mc_cycles = 3) plus load-use in the same cycle -> stall = 001111, bubble_ex = 0; id_branch_taken = 1 throughout -> flush_if = 0 until stall clears, then 1.
REQ-032 SHALL verify reset mid-op: rst pulsed during MC_WAIT with mc_cnt = 3 -> mc_busy = 0, stall = 0, stall_cnt = 0 immediately, with no clock edge required.
REQ-033 SHALL verify the build without PIPE_CTRL_MC_EN: ex_mc_req = 1, ex_mc_cycles = 8 -> stall = 0, mc_busy = 0 for the entire run.

Source files
------------

// File: rtl/pipe_pkg.sv
// ---------------------------------------------------------------------------
// pipe_pkg -- shared constants for the pipeline hazard controller.
//
// Contents:
//   REG_ADDR_WIDTH  register-file address width
//   STALL_WIDTH     width of the stall hold vector
//   STALL_*         bit index of each pipeline register in the stall vector
//   STALL_LOAD_USE  / STALL_MC  stall patterns for the two hazard kinds
//   MC_CNT_WIDTH    width of the multi-cycle down-counter
//   ST_RUN / ST_MC_WAIT  FSM state encoding
// ---------------------------------------------------------------------------
package pipe_pkg;

  localparam int REG_ADDR_WIDTH = 5;

  localparam int STALL_WIDTH   = 6;
  localparam int STALL_PC      = 0;
  localparam int STALL_IF_ID   = 1;
  localparam int STALL_ID_EX   = 2;
  localparam int STALL_EX_MEM  = 3;
  localparam int STALL_MEM_WB  = 4;
  localparam int STALL_RSVD    = 5;

  // Load-use holds PC, IF/ID and ID/EX; a multi-cycle op also holds EX/MEM.
  localparam logic [STALL_WIDTH-1:0] STALL_LOAD_USE = 6'b000111;
  localparam logic [STALL_WIDTH-1:0] STALL_MC       = 6'b001111;

  localparam int MC_CNT_WIDTH = 4;

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_MC_WAIT = 1'b1;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter -- saturating up-counter.
//
// Ports:
//   clk    in   clock, counts on the rising edge
//   rst    in   asynchronous active-high reset, clears the count
//   inc    in   add one this cycle (ignored once the count is all ones)
//   count  out  current count
// ---------------------------------------------------------------------------
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl -- hazard controller for a 5-stage in-order pipeline.
//
// Detects load-use hazards between EX and decode, and holds the pipe while a
// multi-cycle EX operation completes. Stall, bubble and flush outputs are
// combinational from state and inputs; all outputs are 0 while rst is high.
//
// Configuration macro: PIPE_CTRL_MC_EN
//   defined   -> multi-cycle support (MC_WAIT state, mc_cnt down-counter)
//   undefined -> ex_mc_req/ex_mc_cycles are ignored, bubble_mem, mc_busy and
//                stall[3] are tied to 0
//
// Ports:
//   clk, rst                    clock, async active-high reset
//   id_rd_addr1/2, id_rd_en1/2  decode-stage source registers and enables
//   ex_wr_addr, ex_wr_en        EX destination register and write enable
//   ex_is_load                  EX holds a load
//   ex_mc_req, ex_mc_cycles     EX op is multi-cycle, total EX cycles
//   id_branch_taken             decode resolved a taken branch
//   stall[5:0]                  hold vector: PC, IF/ID, ID/EX, EX/MEM, MEM/WB, 0
//   bubble_ex                   ID/EX loads a NOP
//   bubble_mem                  EX/MEM loads a NOP
//   flush_if                    IF/ID loads a NOP
//   mc_busy                     multi-cycle wait in progress
//   stall_cnt                   saturating count of stalled cycles
// ---------------------------------------------------------------------------
module pipe_ctrl
    import pipe_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr1,
    input  logic [REG_ADDR_WIDTH-1:0] id_rd_addr2,
    input  logic                      id_rd_en1,
    input  logic                      id_rd_en2,
    input  logic [REG_ADDR_WIDTH-1:0] ex_wr_addr,
    input  logic                      ex_wr_en,
    input  logic                      ex_is_load,
    input  logic                      ex_mc_req,
    input  logic [MC_CNT_WIDTH-1:0]   ex_mc_cycles,
    input  logic                      id_branch_taken,
    output logic [STALL_WIDTH-1:0]    stall,
    output logic                      bubble_ex,
    output logic                      bubble_mem,
    output logic                      flush_if,
    output logic                      mc_busy,
    output logic [15:0]               stall_cnt
);

    logic in_run;
    logic lu_hazard;

    // Writes to $zero never create a dependency.
    assign lu_hazard = in_run && ex_is_load && ex_wr_en && (ex_wr_addr != '0) &&
                       ((id_rd_en1 && (id_rd_addr1 == ex_wr_addr)) ||
                        (id_rd_en2 && (id_rd_addr2 == ex_wr_addr)));

`ifdef PIPE_CTRL_MC_EN
    logic [0:0]              state;
    logic [MC_CNT_WIDTH-1:0] mc_cnt;
    logic                    mc_start;

    assign in_run   = (state == ST_RUN);
    assign mc_start = in_run && ex_mc_req && (ex_mc_cycles >= 4'd2);
    assign mc_busy  = (state == ST_MC_WAIT);

    // The start cycle is the first stalled cycle and MC_WAIT covers the
    // remaining ex_mc_cycles-2, so the total is ex_mc_cycles-1. A 2-cycle op
    // therefore needs no wait cycles at all and stays in RUN. In MC_WAIT the
    // last wait cycle is the one that sees mc_cnt == 1 (counting down to 0).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= ST_RUN;
            mc_cnt <= '0;
        end else if (state == ST_RUN) begin
            if (mc_start && (ex_mc_cycles > 4'd2)) begin
                state  <= ST_MC_WAIT;
                mc_cnt <= ex_mc_cycles - 4'd2;
            end
        end else begin
            if (mc_cnt <= 4'd1) begin
                state  <= ST_RUN;
                mc_cnt <= '0;
            end else begin
                mc_cnt <= mc_cnt - 4'd1;
            end
        end
    end

    // Multi-cycle start and wait take priority; load-use is re-evaluated
    // once the FSM is back in RUN.
    always_comb begin
        stall      = '0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        if (!rst) begin
            if (mc_busy || mc_start) begin
                stall      = STALL_MC;
                bubble_mem = 1'b1;
            end else if (lu_hazard) begin
                stall     = STALL_LOAD_USE;
                bubble_ex = 1'b1;
            end
        end
    end
`else
    logic mc_unused;

    assign mc_unused = ex_mc_req ^ (^ex_mc_cycles);
    assign in_run    = 1'b1;
    assign mc_busy   = 1'b0;

    always_comb begin
        stall      = '0;
        bubble_ex  = 1'b0;
        bubble_mem = 1'b0;
        if (!rst && lu_hazard) begin
            stall     = STALL_LOAD_USE;
            bubble_ex = 1'b1;
        end
    end
`endif

    // A taken branch waits while decode is held, then flushes IF/ID.
    assign flush_if = ~rst & id_branch_taken & ~stall[STALL_ID_EX];

    sat_counter #(
        .WIDTH (16)
    ) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (stall[STALL_PC]),
        .count (stall_cnt)
    );

endmodule
